rega_wr_arb: RTL and testbench
==============================

# rega_wr_arb

Write-port arbiter and read-forwarding stage for the 4-entry register file. Three writers share the file's single write port: execute writeback (req 0), load unit (req 1) and host/debug port (req 2). One write is accepted per cycle by round-robin and registered into a one-deep issue stage that drives the file's `we`/`wad`/`wd`. Read data for both read ports is forwarded from the issue stage so a consumer never sees a stale value.

## Interface
Parameters:
- DW, 16, data width (matches register width)
- AW, 2, register address width (4 registers)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- hold  in  1  blocks all grants while high
- req_valid  in  3  per-requester write request (bit i = requester i)
- req_ready  out  3  per-requester grant, combinational
- req_addr0/1/2  in  AW each  target register
- req_data0/1/2  in  DW each  write data
- we  out  1  write enable to register file (registered)
- wad  out  AW  write address (registered)
- wd  out  DW  write data (registered)
- arad, brad  in  AW each  read addresses (also fed to register file)
- rf_a, rf_b  in  DW each  raw read data from register file
- a, b  out  DW each  forwarded read data
- wcount  out  16  count of writes issued, wraps

## Operation
- Round-robin pointer `ptr` in {0,1,2}, reset 0. Priority order ptr, ptr+1, ptr+2 (mod 3).
- req_ready[i] = 1 only for the highest-priority requester with req_valid[i]=1; all zero when hold=1 or rst=1. At most one bit set.
- Transfer = req_valid[i] & req_ready[i]. On transfer: ptr <= (i+1) mod 3; issue stage loads we<=1, wad<=req_addr_i, wd<=req_data_i; wcount <= wcount+1 (mod 2^16).
- No transfer: we<=0, wad/wd hold previous values, ptr and wcount unchanged.
- Requester must keep valid/addr/data stable until ready; arbiter does not store rejected requests.
- Two requesters targeting the same register in one cycle: only the winner writes; loser writes in a later cycle (last granted wins in the file).
- Forwarding: a = (we && wad==arad) ? wd : rf_a; same for b with brad. Both ports may forward the same entry. Address 0 is not special (writable, forwardable).
- hold=1: no grants; issue stage drains (we=0 the cycle after hold rises unless a transfer occurred that same earlier cycle); ptr frozen.
- rst=1 at any edge: we=0, wad=0, wd=0, ptr=0, wcount=0; in-flight issue-stage write is discarded (never reaches file). rst does not affect the register file itself.

## Timing
- Reset values: we=0, wad=0, wd=0, wcount=0, req_ready=0 during rst; a/b follow rf_a/rf_b after reset.
- Grant latency: req_ready in same cycle as valid (combinational, zero latency).
- Accept at edge N -> we/wad/wd valid cycle N..N+1 -> register file updated at edge N+1 -> rf_a reflects it from N+1; forwarding covers the cycle between.
- Throughput: one write per cycle sustained; full round-robin fairness, any continuously-valid requester granted within 3 cycles.
- wcount increments at the same edge that loads the issue stage; 0xFFFF + 1 -> 0x0000.
- No combinational path from req_valid to we; a/b are combinational from arad/brad/rf_a/rf_b and issue-stage registers.

## Test plan
- Reset: assert rst 2 cycles with req_valid=3'b111 -> req_ready=0, we=0, wcount=0; first cycle after reset req_ready=3'b001.
- Single writer: req 1 writes addr 2 data 0x1234 -> req_ready=3'b010 same cycle, next cycle we=1 wad=2 wd=0x1234, file reg 2 = 0x1234 one cycle later, wcount=1.
- Contention: all three valid continuously for 6 cycles -> grant sequence 0,1,2,0,1,2, we=1 every cycle, wcount=6.
- Forwarding: write 0x00AB to reg 3 while arad=brad=3 -> in issue cycle a=b=0x00AB with rf_a stale; following cycle a=rf_a=0x00AB.
- Hold: hold=1 for 3 cycles with req 0 and 2 valid -> no grants, we=0 after first cycle, ptr unchanged; on release grant goes to ptr's requester.
- Reset mid-operation: rst asserted the cycle after a grant to reg 1 data 0x5555 -> we=0 next cycle, reg 1 unchanged, ptr=0, wcount=0.

Source files
------------

// File: rtl/rega_wr_arb.sv
// rega_wr_arb: round-robin arbiter for the single register-file write port,
// with a one-deep issue stage and read forwarding for both read ports.
//
// Round-robin pointer states:
//   state | meaning
//   PTR_0 | requester 0 has top priority (order 0,1,2)
//   PTR_1 | requester 1 has top priority (order 1,2,0)
//   PTR_2 | requester 2 has top priority (order 2,0,1)
module rega_wr_arb #(
    parameter int DW = 16,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hold,
    input  logic [2:0]    req_valid,
    output logic [2:0]    req_ready,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [AW-1:0] req_addr2,
    input  logic [DW-1:0] req_data0,
    input  logic [DW-1:0] req_data1,
    input  logic [DW-1:0] req_data2,
    output logic          we,
    output logic [AW-1:0] wad,
    output logic [DW-1:0] wd,
    input  logic [AW-1:0] arad,
    input  logic [AW-1:0] brad,
    input  logic [DW-1:0] rf_a,
    input  logic [DW-1:0] rf_b,
    output logic [DW-1:0] a,
    output logic [DW-1:0] b,
    output logic [15:0]   wcount
);

    typedef enum logic [1:0] {
        PTR_0 = 2'd0,
        PTR_1 = 2'd1,
        PTR_2 = 2'd2
    } ptr_t;

    ptr_t          ptr;
    ptr_t          ptr_nxt;
    logic [1:0]    win;
    logic          xfer;
    logic          we_q;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_data;

    // Pick the highest-priority valid requester and derive the grant and next pointer.
    always_comb begin
        win     = 2'd0;
        ptr_nxt = ptr;
        case (ptr)
            PTR_0:   win = req_valid[0] ? 2'd0 : (req_valid[1] ? 2'd1 : 2'd2);
            PTR_1:   win = req_valid[1] ? 2'd1 : (req_valid[2] ? 2'd2 : 2'd0);
            PTR_2:   win = req_valid[2] ? 2'd2 : (req_valid[0] ? 2'd0 : 2'd1);
            default: win = 2'd0;
        endcase
        xfer      = !rst && !hold && (|req_valid);
        req_ready = xfer ? (3'b001 << win) : 3'b000;
        if (xfer) begin
            case (win)
                2'd0:    ptr_nxt = PTR_1;
                2'd1:    ptr_nxt = PTR_2;
                default: ptr_nxt = PTR_0;
            endcase
        end
    end

    // Route the winning requester's address and data toward the issue stage.
    always_comb begin
        sel_addr = req_addr0;
        sel_data = req_data0;
        case (win)
            2'd1: begin
                sel_addr = req_addr1;
                sel_data = req_data1;
            end
            2'd2: begin
                sel_addr = req_addr2;
                sel_data = req_data2;
            end
            default: begin
                sel_addr = req_addr0;
                sel_data = req_data0;
            end
        endcase
    end

    // Pointer register; only moves on an accepted transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= PTR_0;
        end else begin
            ptr <= ptr_nxt;
        end
    end

    // Issue stage and write counter; address/data hold their value when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            we_q   <= 1'b0;
            wad    <= '0;
            wd     <= '0;
            wcount <= 16'd0;
        end else if (xfer) begin
            we_q   <= 1'b1;
            wad    <= sel_addr;
            wd     <= sel_data;
            wcount <= wcount + 16'd1;
        end else begin
            we_q   <= 1'b0;
        end
    end

    // The in-flight write is suppressed while rst is high so the file never commits it.
    always_comb begin
        we = we_q && !rst;
    end

    // Forward the pending write onto either read port when addresses match.
    always_comb begin
        a = (we && (wad == arad)) ? wd : rf_a;
        b = (we && (wad == brad)) ? wd : rf_b;
    end

endmodule

// File: tb/tb_rega_wr_arb.sv
// Bench for rega_wr_arb: randomized requesters, a behavioural register-file
// environment, a reference model of round-robin and architectural register
// state, and a scoreboard of expected writes checked by a separate monitor.
module tb_rega_wr_arb;

    localparam int DW     = 16;
    localparam int AW     = 2;
    localparam int N_RST  = 2;
    localparam int N_WRAP = 65540;
    localparam int N_RAND = 3000;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk;
    logic          rst;
    logic          hold;
    logic [2:0]    req_valid;
    logic [2:0]    req_ready;
    logic [AW-1:0] ra [3];
    logic [DW-1:0] rd [3];
    logic          we;
    logic [AW-1:0] wad;
    logic [DW-1:0] wd;
    logic [AW-1:0] arad;
    logic [AW-1:0] brad;
    logic [DW-1:0] rf_a;
    logic [DW-1:0] rf_b;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [15:0]   wcount;

    logic [DW-1:0] rf_mem [4];
    wr_t           sb_q [$];
    int            n_vec;
    int            n_err;
    bit            done;

    rega_wr_arb #(.DW(DW), .AW(AW)) dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr0 (ra[0]),
        .req_addr1 (ra[1]),
        .req_addr2 (ra[2]),
        .req_data0 (rd[0]),
        .req_data1 (rd[1]),
        .req_data2 (rd[2]),
        .we        (we),
        .wad       (wad),
        .wd        (wd),
        .arad      (arad),
        .brad      (brad),
        .rf_a      (rf_a),
        .rf_b      (rf_b),
        .a         (a),
        .b         (b),
        .wcount    (wcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file the arbiter writes into.
    always @(posedge clk) begin
        if (we === 1'b1) rf_mem[wad] <= wd;
    end
    assign rf_a = rf_mem[arad];
    assign rf_b = rf_mem[brad];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every presented write must match the oldest expected write.
    always begin
        wr_t e;
        @(posedge clk);
        #4;
        if (!done && we === 1'b1) begin
            if (sb_q.size() == 0) begin
                chk("we_unexpected", {31'd0, we}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("wad", {30'd0, wad}, {30'd0, e.addr});
                chk("wd", {16'd0, wd}, {16'd0, e.data});
            end
        end
    end

    initial begin
        logic [DW-1:0] ref_regs [4];
        logic [2:0]    granted;
        logic [2:0]    exp_ready;
        logic [15:0]   mdl_wc;
        logic [AW-1:0] last_a;
        logic [DW-1:0] last_prev;
        bit            prev_grant;
        bit            free;
        int            mptr;
        int            w;
        int            idx;
        int            total;
        wr_t           e;

        n_vec = 0;
        n_err = 0;
        done  = 1'b0;
        for (int r = 0; r < 4; r++) begin
            rf_mem[r]   = '0;
            ref_regs[r] = '0;
        end
        rst        = 1'b1;
        hold       = 1'b0;
        req_valid  = 3'b111;
        arad       = '0;
        brad       = '0;
        for (int i = 0; i < 3; i++) begin
            ra[i] = '0;
            rd[i] = '0;
        end
        granted    = 3'b000;
        mdl_wc     = 16'd0;
        mptr       = 0;
        prev_grant = 1'b0;
        last_a     = '0;
        last_prev  = '0;
        total      = N_RST + N_WRAP + N_RAND;

        for (int c = 0; c < total; c++) begin
            @(posedge clk);
            #2;
            // Drive this cycle's stimulus.
            if (c < N_RST) begin
                rst  = 1'b1;
                hold = 1'b0;
            end else if (c < N_RST + N_WRAP) begin
                rst  = 1'b0;
                hold = 1'b0;
            end else begin
                rst  = ($urandom_range(0, 49) == 0);
                hold = ($urandom_range(0, 5) == 0);
            end
            for (int i = 0; i < 3; i++) begin
                free = !req_valid[i] || granted[i];
                if (free) begin
                    if (c < N_RST + N_WRAP) req_valid[i] = 1'b1;
                    else req_valid[i] = ($urandom_range(0, 9) < 6);
                    ra[i] = AW'($urandom_range(0, 3));
                    rd[i] = DW'($urandom);
                end
            end
            arad = AW'($urandom_range(0, 3));
            brad = ($urandom_range(0, 3) == 0) ? arad : AW'($urandom_range(0, 3));

            // A reset in the cycle after a grant discards that write.
            if (rst && prev_grant) begin
                void'(sb_q.pop_back());
                ref_regs[last_a] = last_prev;
                prev_grant = 1'b0;
            end

            #4;
            // Reference model: rotating priority starting at mptr.
            exp_ready = 3'b000;
            w = -1;
            if (!rst && !hold) begin
                for (int k = 0; k < 3; k++) begin
                    idx = (mptr + k) % 3;
                    if (w < 0 && req_valid[idx]) w = idx;
                end
                if (w >= 0) exp_ready[w] = 1'b1;
            end

            chk("req_ready", {29'd0, req_ready}, {29'd0, exp_ready});
            chk("fwd_a", {16'd0, a}, {16'd0, ref_regs[arad]});
            chk("fwd_b", {16'd0, b}, {16'd0, ref_regs[brad]});
            chk("wcount", {16'd0, wcount}, {16'd0, mdl_wc});
            chk("sb_drain", sb_q.size(), 32'd0);

            if (w >= 0) begin
                e.addr = ra[w];
                e.data = rd[w];
                sb_q.push_back(e);
                last_a        = ra[w];
                last_prev     = ref_regs[ra[w]];
                ref_regs[ra[w]] = rd[w];
                prev_grant    = 1'b1;
            end else begin
                prev_grant = 1'b0;
            end

            if (rst) begin
                mptr   = 0;
                mdl_wc = 16'd0;
            end else if (w >= 0) begin
                mptr   = (w + 1) % 3;
                mdl_wc = mdl_wc + 16'd1;
            end
            granted = exp_ready;
        end

        @(posedge clk);
        #2;
        rst       = 1'b0;
        hold      = 1'b0;
        req_valid = 3'b000;
        #4;
        chk("sb_final", sb_q.size(), 32'd0);
        chk("wcount_final", {16'd0, wcount}, {16'd0, mdl_wc});
        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
